// File: rtl/vram_text_writer.sv
// Text-mode VRAM writer: interprets a byte stream (printable ASCII plus
// CR/LF/BS/FF), tracks a cursor and emits one-cycle {attr,char} write strobes.
// Each clear state spends one setup cycle with no write, then issues its blank
// writes. The last write is still visible while the FSM sits in the clear
// state, so a write strobe is never seen in IDLE.
module vram_text_writer #(
  parameter int          COLS       = 60,
  parameter int          ROWS       = 34,
  parameter int          ADDR_W     = 11,
  parameter logic [7:0]  BLANK_ATTR = 8'h07
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        char_i,
  input  logic [7:0]        attr_i,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  output logic              vram_cea_o,
  output logic [ADDR_W-1:0] vram_ada_o,
  output logic [15:0]       vram_din_o,
  output logic [5:0]        cur_col_o,
  output logic [5:0]        cur_row_o,
  output logic              busy_o
);
  localparam int               CELLS    = COLS * ROWS;
  localparam int               CNT_W    = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(CELLS);
  localparam logic [CNT_W-1:0] CNT_LINE = CNT_W'(COLS);
  localparam logic [5:0]       LAST_COL = 6'(COLS - 1);
  localparam logic [5:0]       LAST_ROW = 6'(ROWS - 1);
  localparam logic [15:0]      BLANK    = {BLANK_ATTR, 8'h20};

  typedef enum logic [1:0] {CLR_ALL, IDLE, WR, CLR_LINE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // clear progress counter
  logic [5:0]         col_q, col_d;
  logic [5:0]         row_q, row_d;
  logic               wrap_q, wrap_d;   // printable write wrapped the line
  logic               cea_q, cea_d;
  logic [ADDR_W-1:0]  ada_q, ada_d;
  logic [15:0]        din_q, din_d;
  logic               accept;
  logic [5:0]         row_inc;

  // Full-width row*COLS+col, truncated to the VRAM address width.
  function automatic logic [ADDR_W-1:0] cell_addr(input int r, input int c);
    cell_addr = ADDR_W'(r * COLS + c);
  endfunction

  assign accept  = char_valid_i && (state_q == IDLE);
  assign row_inc = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

  // State and datapath registers; reset aborts any clear in progress.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wrap_q  <= 1'b0;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wrap_q  <= wrap_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
    end
  end

  // Next-state: FF/LF go straight to a clear, everything else passes WR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_ALL:  if (cnt_q == CNT_ALL) state_d = IDLE;
      IDLE: if (accept) begin
        if (char_i == 8'h0A)      state_d = CLR_LINE;
        else if (char_i == 8'h0C) state_d = CLR_ALL;
        else                      state_d = WR;
      end
      WR:       state_d = wrap_q ? CLR_LINE : IDLE;
      CLR_LINE: if (cnt_q == CNT_LINE) state_d = IDLE;
      default:  state_d = CLR_ALL;
    endcase
  end

  // Write strobe, address/data and cursor updates.
  always_comb begin
    cea_d  = 1'b0;
    ada_d  = ada_q;
    din_d  = din_q;
    col_d  = col_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case (state_q)
      CLR_ALL: begin
        if (cnt_q != CNT_ALL) begin
          cea_d = 1'b1;
          ada_d = ADDR_W'(cnt_q);
          din_d = BLANK;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          col_d = '0;
          row_d = '0;
        end
      end
      CLR_LINE: begin
        if (cnt_q != CNT_LINE) begin
          cea_d = 1'b1;
          ada_d = cell_addr(int'(row_q), int'(cnt_q));
          din_d = BLANK;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (char_i >= 8'h20 && char_i <= 8'h7E) begin
            cea_d = 1'b1;
            ada_d = cell_addr(int'(row_q), int'(col_q));
            din_d = {attr_i, char_i};
            if (col_q == LAST_COL) begin
              col_d  = '0;
              row_d  = row_inc;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else begin
            case (char_i)
              8'h0D: col_d = '0;
              8'h0A: row_d = row_inc;
              8'h08: if (col_q != 6'd0) begin
                col_d = col_q - 6'd1;
                cea_d = 1'b1;
                ada_d = cell_addr(int'(row_q), int'(col_q) - 1);
                din_d = BLANK;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign char_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q == CLR_ALL) || (state_q == CLR_LINE);
  assign vram_cea_o   = cea_q;
  assign vram_ada_o   = ada_q;
  assign vram_din_o   = din_q;
  assign cur_col_o    = col_q;
  assign cur_row_o    = row_q;
endmodule

// File: tb/tb_vram_text_writer.sv
// Directed bench for vram_text_writer: write strobes are logged on the falling
// edge and checked against hand-computed addresses and data.
module tb_vram_text_writer;
  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  char_v, attr_v;
  logic        valid;
  logic        ready, cea, busy;
  logic [10:0] ada;
  logic [15:0] din;
  logic [5:0]  col, row;

  typedef struct packed {
    logic        busy;
    logic [10:0] ada;
    logic [15:0] din;
  } wr_t;
  wr_t wq[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vram_text_writer dut (
    .clk_i(clk), .rstn_i(rstn), .char_i(char_v), .attr_i(attr_v),
    .char_valid_i(valid), .char_ready_o(ready), .vram_cea_o(cea),
    .vram_ada_o(ada), .vram_din_o(din), .cur_col_o(col), .cur_row_o(row),
    .busy_o(busy)
  );

  // Log every write strobe.
  always @(negedge clk) if (cea) wq.push_back('{busy, ada, din});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    wait_ready(5000);
    char_v = c;
    attr_v = a;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_cea", cea, 0);
    chk("rst_ada", ada, 0);
    chk("rst_din", din, 0);
    chk("rst_ready", ready, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_busy", busy, 1);
  endtask

  initial begin
    int bad;
    rstn = 1'b0; valid = 1'b0; char_v = 8'h00; attr_v = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outs();

    // Power-up clear of the whole screen.
    rstn = 1'b1;
    wait_ready(3000);
    chk("clrall_cnt", wq.size(), 2040);
    bad = 0;
    foreach (wq[i]) if (wq[i].ada != 11'(i) || wq[i].din != 16'h0720) bad++;
    chk("clrall_seq", bad, 0);
    chk("clrall_ready", ready, 1);
    chk("clrall_col", col, 0);
    chk("clrall_row", row, 0);
    chk("clrall_busy", busy, 0);

    // Single printable byte.
    wq.delete();
    send(8'h41, 8'h1E);
    chk("A_cea", cea, 1);
    chk("A_ada", ada, 0);
    chk("A_din", din, 16'h1E41);
    chk("A_col", col, 1);
    chk("A_row", row, 0);
    chk("A_ready_wr", ready, 0);
    @(negedge clk);
    chk("A_ready_back", ready, 1);
    chk("A_cea_idle", cea, 0);
    chk("A_hold_ada", ada, 0);

    // CR then five LFs: cursor to (0,5).
    send(8'h0D, 8'h00);
    repeat (5) send(8'h0A, 8'h00);
    wait_ready(500);
    chk("r5_col", col, 0);
    chk("r5_row", row, 5);

    // Fill row 5 -> wrap, clear of row 6.
    wq.delete();
    for (int i = 0; i < 60; i++) send(8'h61 + 8'(i % 26), 8'h2F);
    wait_ready(500);
    chk("fill_cnt", wq.size(), 120);
    bad = 0;
    for (int i = 0; i < 60; i++)
      if (wq[i].ada != 11'(300 + i) || wq[i].din != {8'h2F, 8'h61 + 8'(i % 26)}) bad++;
    chk("fill_seq", bad, 0);
    chk("fill_last_ada", wq[59].ada, 359);
    bad = 0;
    for (int i = 60; i < 120; i++)
      if (wq[i].ada != 11'(300 + i) || wq[i].din != 16'h0720 || !wq[i].busy) bad++;
    chk("fill_clr_seq", bad, 0);
    chk("fill_clr_first", wq[60].ada, 360);
    chk("fill_clr_last", wq[119].ada, 419);
    chk("fill_col", col, 0);
    chk("fill_row", row, 6);

    // Cursor to (3,33), then LF wraps row to 0.
    repeat (27) send(8'h0A, 8'h00);
    send(8'h61, 8'h07); send(8'h62, 8'h07); send(8'h63, 8'h07);
    wait_ready(500);
    chk("p33_col", col, 3);
    chk("p33_row", row, 33);
    wq.delete();
    send(8'h0A, 8'h00);
    wait_ready(500);
    chk("lfw_col", col, 3);
    chk("lfw_row", row, 0);
    chk("lfw_cnt", wq.size(), 60);
    bad = 0;
    foreach (wq[i]) if (wq[i].ada != 11'(i) || wq[i].din != 16'h0720) bad++;
    chk("lfw_seq", bad, 0);

    // FF, two LFs -> (0,2); X, BS, BS.
    send(8'h0C, 8'h00);
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    wait_ready(3000);
    wq.delete();
    send(8'h58, 8'h1E);
    wait_ready(10);
    chk("X_col", col, 1);
    send(8'h08, 8'h00);
    wait_ready(10);
    chk("bs1_col", col, 0);
    chk("bs1_row", row, 2);
    send(8'h08, 8'h00);
    wait_ready(10);
    chk("bs2_col", col, 0);
    chk("bs2_row", row, 2);
    chk("bs_cnt", wq.size(), 2);
    chk("X_wr", {5'd0, wq[0].ada, wq[0].din}, {5'd0, 11'd120, 16'h1E58});
    chk("bs1_wr", {5'd0, wq[1].ada, wq[1].din}, {5'd0, 11'd120, 16'h0720});

    // Unknown byte and CR produce no writes.
    send(8'h5A, 8'h07);
    wait_ready(10);
    wq.delete();
    send(8'h01, 8'h07);
    wait_ready(10);
    chk("unk_col", col, 1);
    chk("unk_nowr", wq.size(), 0);
    send(8'h0D, 8'h07);
    wait_ready(10);
    chk("cr_col", col, 0);
    chk("cr_nowr", wq.size(), 0);

    // Reset in the middle of a full clear.
    send(8'h0C, 8'h00);
    begin
      int n = 0;
      while (ada < 11'd1000 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (ada < 11'd1000) chk("ff_timeout", ada, 1000);
    end
    chk("ff_mid_busy", busy, 1);
    chk("ff_mid_row", row, 2);
    rstn = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk);
    wq.delete();
    rstn = 1'b1;
    wait_ready(3000);
    chk("rerun_cnt", wq.size(), 2040);
    chk("rerun_first", wq[0].ada, 0);
    chk("rerun_last", wq[2039].ada, 2039);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vram_text_writer.md
Name: vram_text_writer

Overview:
- Producer side of the text-mode VRAM write port consumed by the `video` block. It is the writer that fills the memory the LCD timing engine reads.
- Accepts a byte stream over a valid/ready handshake and interprets printable ASCII plus a small set of control codes.
- Maintains a cursor and emits one-cycle VRAM write strobes carrying {attribute, character} words.
- Sits between a byte source (UART receiver, CPU port) and the `vram_*` inputs of `video`, in the same clock domain as the VRAM write clock.

Parameters:
- COLS, 60, text columns (480/8).
- ROWS, 34, text rows (272/8).
- ADDR_W, 11, VRAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK_ATTR, 8'h07, attribute written with 0x20 (space) during clears.

Ports:
- clk_i  in  1  write clock; also drives VRAM write clock.
- rstn_i  in  1  asynchronous active-low reset.
- char_i  in  8  byte to interpret.
- attr_i  in  8  attribute (fg[3:0] low nibble, bg[7:4] high nibble), sampled together with char_i.
- char_valid_i  in  1  char_i/attr_i valid.
- char_ready_o  out  1  writer can accept a byte this cycle.
- vram_cea_o  out  1  one-cycle VRAM write enable.
- vram_ada_o  out  ADDR_W  VRAM write address = row*COLS + col.
- vram_din_o  out  16  {attr, char}.
- cur_col_o  out  6  cursor column.
- cur_row_o  out  6  cursor row.
- busy_o  out  1  high while a line or screen clear is in progress.

Behaviour:
- Reset (async assert, sync release):
  - vram_cea_o=0, vram_ada_o=0, vram_din_o=0, char_ready_o=0, col=0, row=0, busy_o=1.
  - After release, the FSM enters CLR_ALL.
- FSM states: CLR_ALL, IDLE, WR, CLR_LINE.
- char_ready_o = 1 only in IDLE. A byte is accepted when char_valid_i && char_ready_o; the FSM always leaves IDLE on the following cycle.
- Printable bytes 0x20..0x7E:
  - Accepted at cycle N. vram_cea_o=1 at N+1 with addr(row,col) and din={attr_i,char_i}, both captured at N.
  - col increments at N+1.
  - If col was COLS-1: col wraps to 0, row advances, and the FSM enters CLR_LINE for the new row. Otherwise it returns to IDLE at N+2.
- 0x0D (CR): col=0, no VRAM write, return to IDLE next cycle.
- 0x0A (LF): row advances, col unchanged, then CLR_LINE.
- 0x08 (BS): if col>0, col decrements and a space with BLANK_ATTR is written at the new col. If col==0, the byte is consumed and nothing happens.
- 0x0C (FF): enter CLR_ALL.
- Any other byte: consumed silently; no write, no cursor change.
- Row advance: row+1; ROWS-1 wraps to 0. There is no scrolling; the destination row is overwritten after its clear.
- CLR_LINE:
  - Issues COLS consecutive writes, one per cycle, to addr(row,0..COLS-1) with din={BLANK_ATTR,8'h20}.
  - busy_o=1 throughout. Return to IDLE the cycle after the last write.
- CLR_ALL:
  - Issues COLS*ROWS consecutive writes to addresses 0..COLS*ROWS-1 with the blank word.
  - Cursor is set to (0,0), then return to IDLE.
  - Duration is exactly COLS*ROWS cycles of vram_cea_o=1.
- vram_cea_o is never high in IDLE.
- vram_ada_o and vram_din_o hold their last value when vram_cea_o=0.
- Addresses never reach or exceed COLS*ROWS.
- Address arithmetic: row*COLS computed as a full-width product truncated to ADDR_W. With the defaults the maximum is 2039, which fits 11 bits.
- A reset asserted mid-clear or mid-write aborts the operation immediately. After release the block restarts CLR_ALL from address 0.
- char_valid_i while char_ready_o=0: no effect; the source must hold the byte.

Test Plan:
- Reset release -> exactly 2040 vram_cea_o pulses, addresses 0..2039 ascending, din=16'h0720; then char_ready_o=1 and cursor (0,0).
- Send 'A' (0x41) with attr 0x1E at cursor (0,0) -> one pulse next cycle, ada=0, din=16'h1E41; cursor (1,0); ready again 2 cycles after accept.
- Fill 60 printable bytes on row 5 -> 60th write at ada=359; cursor (0,6); then 60 clear writes at ada 360..419; busy_o=1 during the clear.
- Cursor (3,33), send LF -> row wraps to 0, col stays 3; clear writes at ada 0..59.
- Sequence 'X', BS, BS with cursor starting at (0,2) -> X written at 120; first BS writes 16'h0720 at ada 120 with cursor (0,2); second BS produces no write and cursor stays (0,2).
- Assert rstn_i during an FF clear at address ~1000 -> all outputs drop to reset values immediately; after release, the clear restarts at address 0.
